// File: rtl/sync_fifo_drain_if.sv
// Handshake bundle between a synchronous FIFO read port, the drain engine and its valid/ready consumer.
interface sync_fifo_drain_if #(
  parameter int unsigned WIDTH = 64
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_ren;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_ren, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_ren, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo_drain.sv
// Pops a 1-cycle-latency FIFO into a 2-entry skid buffer and presents it as a full-rate valid/ready stream.
// Optional SYNC_FIFO_DRAIN_STATS_EN adds a 32-bit popped-word counter on o_word_cnt.
module sync_fifo_drain #(
  parameter int unsigned WIDTH = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  sync_fifo_drain_if.master bus,
  output logic [1:0]        o_occupancy
`ifdef SYNC_FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]       o_word_cnt
`endif
);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LVL_W = 3;

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic             r_head;
  logic             r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_inflight;

  logic             w_valid;
  logic             w_pop;
  logic             w_ren;
  logic [LVL_W-1:0] w_level;

  assign w_valid = (r_count != '0);

  // Level after this cycle's pop and capture; a new pop is only issued while a slot is guaranteed free.
  always_comb begin
    w_pop   = w_valid && bus.m_ready;
    w_level = LVL_W'(r_count) + LVL_W'(r_inflight) - LVL_W'(w_pop);
    w_ren   = !i_reset && !bus.fifo_empty && (w_level < LVL_W'(DEPTH));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      if (r_inflight) begin
        r_buf[r_tail] <= bus.fifo_dout;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= CNT_W'(w_level);
    end
  end

  assign bus.fifo_ren = w_ren;
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = r_buf[r_head];
  assign o_occupancy  = r_count;

`ifdef SYNC_FIFO_DRAIN_STATS_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign o_word_cnt = r_word_cnt;
`endif

  // Buffered plus in-flight words can never exceed the two slots.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_reset)
    (LVL_W'(r_count) + LVL_W'(r_inflight)) <= LVL_W'(DEPTH));

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Bench for sync_fifo_drain: queue-based FIFO emulation, per-cycle reference model, end-to-end scoreboard.
module tb_sync_fifo_drain;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_drain_if #(.WIDTH(W)) bus ();
  logic [1:0] occupancy;
`ifdef SYNC_FIFO_DRAIN_STATS_EN
  logic [31:0] word_cnt;
`endif

  sync_fifo_drain #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .bus         (bus),
    .o_occupancy (occupancy)
`ifdef SYNC_FIFO_DRAIN_STATS_EN
    ,
    .o_word_cnt  (word_cnt)
`endif
  );

  logic [W-1:0] fifo_q [$];
  logic [W-1:0] sb_q [$];
  logic [W-1:0] m_q [$];
  logic         m_inf = 1'b0;
  logic [W-1:0] m_inf_word = '0;
  logic         ren_s = 1'b0;
  logic [W-1:0] first_data = '0;
  int cyc = 0, cnt_ren = 0, cnt_valid = 0, cnt_hs = 0;
  int first_v = -1, last_v = -1, first_r = -1;
  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    cnt_ren = 0; cnt_valid = 0; cnt_hs = 0;
    first_v = -1; last_v = -1; first_r = -1;
  endtask

  // Model: the words the buffer must hold, plus the word that a pop issued last cycle will deliver.
  always @(negedge clk) begin : compare
    logic pop_e, ren_e;
    int   lvl;
    ren_s = bus.fifo_ren;
    if (reset) begin
      chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
      chk("rst_fifo_ren", 64'(bus.fifo_ren), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_m_data", 64'(bus.m_data), 64'(0));
      m_q.delete();
      m_inf = 1'b0;
    end else begin
      pop_e = (m_q.size() != 0) && bus.m_ready;
      lvl   = m_q.size() + int'(m_inf) - int'(pop_e);
      ren_e = !bus.fifo_empty && (lvl < 2);
      chk("m_valid", 64'(bus.m_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("m_data", 64'(bus.m_data), 64'(m_q[0]));
      chk("fifo_ren", 64'(bus.fifo_ren), 64'(ren_e));
      chk("occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("ren_while_empty", 64'(bus.fifo_ren & bus.fifo_empty), 64'(0));
      if (bus.m_valid && bus.m_ready) begin
        cnt_hs++;
        chk("sb_has_word", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) chk("sb_data", 64'(bus.m_data), 64'(sb_q.pop_front()));
      end
      if (bus.fifo_ren) begin
        cnt_ren++;
        if (first_r < 0) first_r = cyc;
      end
      if (bus.m_valid) begin
        cnt_valid++;
        if (first_v < 0) begin
          first_v    = cyc;
          first_data = bus.m_data;
        end
        last_v = cyc;
      end
      if (pop_e) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_word);
      m_inf = ren_e;
      if (ren_e && fifo_q.size() != 0) m_inf_word = fifo_q[0];
    end
    cyc++;
  end

  // One clock of the emulated FIFO: an accepted ren delivers the head word just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ren_s) begin
      chk("fifo_underflow", 64'(fifo_q.size() != 0), 64'(1));
      if (fifo_q.size() != 0) bus.fifo_dout = fifo_q.pop_front();
    end else begin
      bus.fifo_dout = {$urandom, $urandom};
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  initial begin : stim
    int n0;
    int pushed;
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_dout  = '0;
    #1;
    chk("init_m_valid", 64'(bus.m_valid), 64'(0));
    chk("init_fifo_ren", 64'(bus.fifo_ren), 64'(0));
    chk("init_occupancy", 64'(occupancy), 64'(0));
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single word: ren at N, valid at N+2 for exactly one cycle.
    clr_stats();
    bus.m_ready = 1'b1;
    push(64'hDEAD_BEEF_0000_0001);
    n0 = cyc;
    repeat (6) tick();
    chk("t2_ren_cycles", 64'(cnt_ren), 64'(1));
    chk("t2_ren_cycle", 64'(first_r), 64'(n0));
    chk("t2_valid_cycle", 64'(first_v), 64'(n0 + 2));
    chk("t2_valid_cycles", 64'(cnt_valid), 64'(1));
    chk("t2_data", 64'(first_data), 64'hDEAD_BEEF_0000_0001);

    // Streaming 0..7 with no bubbles.
    clr_stats();
    for (int i = 0; i < 8; i++) push(64'(i));
    n0 = cyc;
    repeat (14) tick();
    chk("t3_first_valid", 64'(first_v), 64'(n0 + 2));
    chk("t3_span", 64'(last_v - first_v), 64'(7));
    chk("t3_words", 64'(cnt_hs), 64'(8));
    chk("t3_ren_cycles", 64'(cnt_ren), 64'(8));

    // Backpressure: two pops fill the buffer, then everything drains in order.
    clr_stats();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(64'(i));
    repeat (10) tick();
    chk("t4_ren_cycles", 64'(cnt_ren), 64'(2));
    chk("t4_occupancy", 64'(occupancy), 64'(2));
    chk("t4_m_data", 64'(bus.m_data), 64'(0));
    bus.m_ready = 1'b1;
    repeat (14) tick();
    chk("t4_words", 64'(cnt_hs), 64'(8));
    chk("t4_sb_drained", 64'(sb_q.size()), 64'(0));

    // Reset mid-stream with a full buffer; two buffered words are lost.
    clr_stats();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(64'(100 + i));
    repeat (5) tick();
    chk("t1_occ_before", 64'(occupancy), 64'(2));
    tick();
    reset = 1'b1;
    #1;
    chk("t1_m_valid", 64'(bus.m_valid), 64'(0));
    chk("t1_fifo_ren", 64'(bus.fifo_ren), 64'(0));
    chk("t1_occupancy", 64'(occupancy), 64'(0));
    sb_q = fifo_q;
    repeat (2) tick();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    clr_stats();
    repeat (12) tick();
    chk("t1_first_word", 64'(first_data), 64'(102));
    chk("t1_words", 64'(cnt_hs), 64'(6));

    // Random stalls and refills.
    clr_stats();
    pushed = 0;
    for (int c = 0; c < 40000 && cnt_hs < 10000; c++) begin
      tick();
      bus.m_ready = 1'($urandom_range(0, 1));
      if (pushed < 10000 && fifo_q.size() < 8 && $urandom_range(0, 3) != 0) begin
        push({$urandom, $urandom});
        pushed++;
      end
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
    chk("t5_words", 64'(cnt_hs), 64'(10000));
    chk("t5_sb_drained", 64'(sb_q.size()), 64'(0));

`ifdef SYNC_FIFO_DRAIN_STATS_EN
    // Counter counts pops since reset and wraps at 2^32.
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(64'(200 + i));
    repeat (10) tick();
    chk("t6_word_cnt", 64'(word_cnt), 64'(5));
    bus.m_ready = 1'b0;
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.r_word_cnt;
    chk("t6_preload", 64'(word_cnt), 64'h0000_0000_FFFF_FFFF);
    push(64'(300));
    bus.m_ready = 1'b1;
    repeat (5) tick();
    chk("t6_wrap", 64'(word_cnt), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
